ssa_conv_sequencer: RTL and testbench
=====================================

# ssa_conv_sequencer

Sequencing controller for the 16-bit SSA multiplier datapath. It accepts one operand pair through a valid/ready handshake, splits each operand into eight 2-bit digits, and computes the eight low-order acyclic convolution coefficients c_k = sum over i+j=k of a_i*b_j (k=0..7) with a time-shared digit multiply-accumulate. It presents the coefficients on the packed 96-bit coefficient bus consumed by the merge stage, together with the merged 16-bit product.

## Interface
- Parameters: none. Widths are fixed: 16-bit operands, eight 2-bit digits, 9-bit coefficient fields.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept an operand pair
- a  in  16  operand A; digit a_i = a[2i+1:2i]
- b  in  16  operand B; digit b_j = b[2j+1:2j]
- out_valid  out  1  coef and product are valid
- out_ready  in  1  consumer accepts the result
- coef  out  96  c_k in bits [9k+8:9k] for k=0..7; bits [95:72] always 0
- product  out  16  sum over k of (c_k << 2k), truncated to 16 bits; equals (a*b) mod 2^16
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a and b, clear all eight accumulators, set k=0 and i=0, go to RUN.
- RUN (serial MAC, default build):
  - Each cycle, acc[k] += a_i * b_(k-i).
  - If i<k, increment i. Otherwise set i=0 and increment k.
  - On the update with k=7, i=7, go to DONE.
  - The pass covers 36 terms (1+2+...+8).
- DONE:
  - out_valid=1. coef and product are held stable.
  - On out_ready, go to IDLE.
  - Accumulators keep their values until the next acceptance.
- Arithmetic:
  - Each digit product is at most 9.
  - Each c_k is at most 9*(k+1), at most 72, so 9 bits never overflow.
  - product is a combinational merge of the coef registers. Sum bits above 15 are discarded.
- in_valid is ignored outside IDLE (in_ready=0). Latched operands do not change while busy.
- rst in any state, including mid-RUN:
  - Next state is IDLE.
  - Accumulators, counters and operand registers are cleared.
  - No out_valid is produced for the aborted operation.

## Timing
- Reset values:
  - in_ready=1 (IDLE).
  - out_valid=0, busy=0, coef=0, product=0.
- Acceptance edge E0 is the edge where in_valid and in_ready are both high.
- Serial build:
  - RUN performs MAC updates on edges E1..E36.
  - DONE is entered at E36. out_valid is high from E36 onward.
- Parallel build:
  - Updates occur on edges E1..E8.
  - out_valid is high from E8 onward.
- Result handshake edge H is the edge where out_valid and out_ready are both high.
  - IDLE is entered at H. in_ready is high from H onward.
  - The next acceptance is no earlier than H+1.
  - Minimum issue interval is 38 cycles (serial) or 10 cycles (parallel).
- out_ready is ignored outside DONE.
- in_ready and out_valid are never high in the same cycle.

## Configuration
- SSA_PARALLEL_MAC_EN is the single configuration macro.
- Defined:
  - RUN computes one whole coefficient per cycle: acc[k] = sum of all k+1 digit products. Only k is stepped.
  - RUN is 8 cycles.
- Undefined (default):
  - Serial single-digit MAC as described under Operation.
  - RUN is 36 cycles.
- Interface, handshake and results are identical in both builds; only latency differs.

## Test plan
- a=0x0003, b=0x0005 -> c0=3, c1=3, all other c_k=0; product=0x000F.
- a=0xFFFF, b=0xFFFF -> c_k=9(k+1), i.e. 9,18,...,72; product=0x0001; no field exceeds 72.
- a=0x1234, b=0x5678 -> product=0x0060. out_valid rises exactly 36 cycles after E0 (8 cycles with SSA_PARALLEL_MAC_EN).
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new operands -> coef and product unchanged, in_ready=0 throughout, single result delivered once out_ready=1.
- Assert rst for 1 cycle at E20 of a RUN -> next cycle in_ready=1, out_valid=0, coef=0; a following pair a=2, b=2 yields product=0x0004.
- Back-to-back operations with out_ready and in_valid held high -> acceptances spaced 38 cycles apart (10 with parallel build), each result correct.

Source files
------------

// File: rtl/ssa_conv_sequencer.sv
// Sequencer for the 16-bit SSA multiplier: eight-digit acyclic convolution via digit MAC.
// Build option: define SSA_PARALLEL_MAC_EN for one whole coefficient per RUN cycle (8 cycles instead of 36).
module ssa_conv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] coef,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  i_q, i_d;
  logic [8:0]  acc_q [8];
  logic [8:0]  acc_d [8];
`ifdef SSA_PARALLEL_MAC_EN
  logic [8:0]  par_sum;
`endif

  function automatic logic [1:0] digit(input logic [15:0] v, input logic [2:0] idx);
    return v[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [8:0] dmul(input logic [1:0] x, input logic [1:0] y);
    return 9'(x) * 9'(y);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    i_d       = i_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
`ifdef SSA_PARALLEL_MAC_EN
    par_sum   = '0;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '{default: '0};
          k_d     = '0;
          i_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
`ifdef SSA_PARALLEL_MAC_EN
        for (int ii = 0; ii < 8; ii++) begin
          if (3'(ii) <= k_q)
            par_sum = par_sum + dmul(digit(a_q, 3'(ii)), digit(b_q, 3'(k_q - 3'(ii))));
        end
        acc_d[k_q] = par_sum;
        if (k_q == 3'd7) begin
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
`else
        acc_d[k_q] = acc_q[k_q] + dmul(digit(a_q, i_q), digit(b_q, 3'(k_q - i_q)));
        // Walk the anti-diagonal i+j=k, then move to the next coefficient.
        if (i_q < k_q) begin
          i_d = i_q + 3'd1;
        end else begin
          i_d = '0;
          if (k_q == 3'd7) begin
            k_d     = '0;
            state_d = S_DONE;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
`endif
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Merge stage view: packed coefficients and the shifted sum of them.
  always_comb begin
    coef    = '0;
    product = '0;
    for (int kk = 0; kk < 8; kk++) begin
      coef[9*kk +: 9] = acc_q[kk];
      product         = product + (16'(acc_q[kk]) << (2 * kk));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      // NOTE: the accumulator array is reset on purpose; coef and product must read zero after reset.
      for (int kk = 0; kk < 8; kk++) acc_q[kk] <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      i_q     <= i_d;
      for (int kk = 0; kk < 8; kk++) acc_q[kk] <= acc_d[kk];
    end
  end

endmodule

// File: tb/tb_ssa_conv_sequencer.sv
// Scoreboard bench for ssa_conv_sequencer: directed operand pairs, decoupled result monitor.
module tb_ssa_conv_sequencer;

`ifdef SSA_PARALLEL_MAC_EN
  localparam int LAT = 8;
  localparam int GAP = 10;
`else
  localparam int LAT = 36;
  localparam int GAP = 38;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] coef;
  logic [15:0] product;
  logic        busy;

  ssa_conv_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .coef     (coef),
    .product  (product),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] coef;
    logic [15:0] product;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   delivered = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference convolution straight from the definition c_k = sum_{i+j=k} a_i*b_j.
  function automatic logic [95:0] conv(input logic [15:0] x, input logic [15:0] y);
    logic [95:0] c = '0;
    for (int k = 0; k < 8; k++) begin
      int s = 0;
      for (int i = 0; i <= k; i++)
        s += int'(x[2*i +: 2]) * int'(y[2*(k-i) +: 2]);
      c[9*k +: 9] = 9'(s);
    end
    return c;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a pair, wait (bounded) for acceptance, push the expected result.
  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] exp_p,
                       input bit keep_valid, output int e0);
    bit found = 0;
    exp_t e;
    a = va;
    b = vb;
    in_valid = 1'b1;
    e0 = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      check("accept_timeout", 1, 0);
    end else begin
      @(posedge clk);
      #1;
      e0 = cyc;
      e.coef = conv(va, vb);
      e.product = exp_p;
      sb.push_back(e);
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check({name, "_out_valid_timeout"}, 1, 0);
  endtask

  // Result monitor: pops and compares on each result handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) check("ready_valid_exclusive", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("coef", coef, e.coef);
          check("product", {80'd0, product}, {80'd0, e.product});
          delivered++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int e0, e1, lat, d0;
    logic [95:0] hold_coef;

    step(3);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_coef", coef, 0);
    check("rst_product", product, 0);

    // Small operands: c0=3, c1=3.
    out_ready = 1'b1;
    issue(16'h0003, 16'h0005, 16'h000F, 0, e0);
    wait_out_valid("t1", lat);
    check("t1_latency", lat, LAT);
    step(2);

    // All-ones: c_k = 9(k+1).
    issue(16'hFFFF, 16'hFFFF, 16'h0001, 0, e0);
    wait_out_valid("t2", lat);
    step(2);

    issue(16'h1234, 16'h5678, 16'h0060, 0, e0);
    wait_out_valid("t3", lat);
    check("t3_latency", lat, LAT);
    step(2);

    // Stall in DONE while new operands are offered.
    out_ready = 1'b0;
    d0 = delivered;
    issue(16'hA5C3, 16'h3C96, 16'hD442, 0, e0);
    wait_out_valid("t4", lat);
    hold_coef = conv(16'hA5C3, 16'h3C96);
    for (int t = 0; t < 10; t++) begin
      in_valid = ~in_valid;
      a = 16'(16'h1111 * (t + 1));
      b = 16'(16'h0707 * (t + 2));
      step(1);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_coef", coef, hold_coef);
      check("hold_product", product, 16'hD442);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(1);
    check("hold_release_in_ready", in_ready, 1);
    check("hold_release_out_valid", out_valid, 0);
    step(3);
    check("hold_single_delivery", delivered - d0, 1);

    // Abort mid-RUN with a one-cycle reset sampled at E20.
    issue(16'hFFFF, 16'h0003, 16'h0000, 0, e0);
    step(19);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_coef", coef, 0);
    check("abort_product", product, 0);
    issue(16'h0002, 16'h0002, 16'h0004, 0, e0);
    wait_out_valid("t5", lat);
    step(2);

    // Back-to-back with both handshakes held high.
    issue(16'h0101, 16'h0202, 16'h0402, 1, e0);
    issue(16'h00FF, 16'h0011, 16'h10EF, 1, e1);
    check("b2b_gap_1", e1 - e0, GAP);
    issue(16'h8000, 16'h0003, 16'h8000, 0, e0);
    check("b2b_gap_2", e0 - e1, GAP);
    wait_out_valid("t6", lat);
    check("t6_latency", lat, LAT);
    step(3);

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
